seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a NUM_DIGITS common-segment 7-seg display.
//  Latches a packed BCD word, cycles one-hot digit enables at a prescaled rate,
//  and drives the existing BCD_Seven_segment decoder with the active digit.
//  Registered seg/anode outputs; per-slot blanking window prevents ghosting.
// PARAMETERS
//  NUM_DIGITS    4     digits scanned (>=2)
//  DIV           1000  clk cycles per digit slot (>=2)
//  BLANK_CYCLES  16    cycles at slot start with anodes off (0 <= BLANK_CYCLES < DIV)
// PORTS
//  clk      in   1               rising-edge clock
//  rst      in   1               synchronous, active-high reset
//  en       in   1               scan enable; low freezes scan and blanks display
//  load     in   1               capture bcd_in into shadow register this cycle
//  bcd_in   in   4*NUM_DIGITS    packed BCD, digit k = bcd_in[4k+3:4k], digit 0 = LS
//  seg_out  out  7               segments {a..g} = [6:0], active-high
//  an_out   out  NUM_DIGITS      digit enables, one-hot or zero, active-high
//  digit_wrap out 1              1-cycle pulse when scan wraps digit NUM_DIGITS-1 -> 0
// BEHAVIOUR
//  - Reset: shadow=0, presc=0, idx=0, seg_out=0, an_out=0, digit_wrap=0.
//  - load=1: shadow <= bcd_in at edge; new value visible on outputs next edge (1-cycle latency).
//  - en=1: presc counts 0..DIV-1; at presc==DIV-1, presc<=0, idx<=(idx==NUM_DIGITS-1)?0:idx+1.
//  - en=0: presc/idx hold; an_out<=0, seg_out<=0 next edge. Load still honoured.
//  - Outputs registered from current presc/idx: an_out<=0 while presc<BLANK_CYCLES,
//    else an_out<=1<<idx. seg_out<=decode(shadow digit idx) whenever en=1.
//  - Invalid BCD digit (>9): seg_out forced to 7'b0000001 (dash, g only).
//  - digit_wrap asserted the cycle after idx transitions NUM_DIGITS-1 -> 0.
//  - load coincident with slot change: new shadow and new idx both apply; no lost update.
//  - rst mid-slot: all state cleared same edge; scan restarts at digit 0, presc 0.
//  - BLANK_CYCLES=0: an_out[0] asserted first edge after rst deasserts (with en=1).
//  - Width: presc is $clog2(DIV) bits; idx is $clog2(NUM_DIGITS) bits; no wrap beyond limits.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: digit k>0 whose value and all higher digits are 0
//   gets an_out bit held 0 for its slot (timing unchanged); digit 0 always shown.
//  Not defined: every digit displayed, zeros included.
// STRUCTURE
//  Package seven_seg_pkg: SEG_DASH, SEG_BLANK constants, BCD_MAX=4'd9.
//  Sub-module: BCD_Seven_segment (existing decoder), one instance, muxed digit in.
//  Rest flat: prescaler, digit index counter, shadow reg, output regs, LZ mask logic.
// TESTING  (NUM_DIGITS=4, DIV=8, BLANK_CYCLES=2)
//  1 rst held 3 cycles then released, en=1 -> an_out=0 cycles 1-2, an_out=4'b0001 cycle 3.
//  2 load bcd_in=16'h1234 -> slots show an_out 0001/0010/0100/1000 with decoded 4,3,2,1;
//    digit_wrap pulses once per 32 cycles.
//  3 load 16'h00A5 -> digit 1 slot seg_out=7'b0000001; digit 0 shows decoded 5.
//  4 en=0 mid-slot for 10 cycles -> an_out=0, presc/idx frozen; en=1 resumes same slot/count.
//  5 rst pulse during digit 2 slot -> next edge all outputs 0, scan restarts at digit 0.
//  6 LEADING_ZERO_BLANK_EN, load 16'h0070 -> digits 3,2 slots an_out=0; digits 1,0 shown (7,0).

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan controller and its decoder.
// Segment vectors are {a,b,c,d,e,f,g} on bits [6:0], active-high.
package seven_seg_pkg;

  // Dash shown for any BCD digit above nine: only segment g lit.
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  // All segments off.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Largest legal BCD digit value.
  localparam logic [3:0] BCD_MAX   = 4'd9;

endpackage : seven_seg_pkg

// File: rtl/BCD_Seven_segment.sv
// Combinational BCD to seven-segment decoder, segments {a..g} = [6:0], active-high.
// Codes above nine decode to a dash so a corrupt digit is visible rather than dark.
module BCD_Seven_segment
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Map one BCD digit to its segment pattern; out-of-range digits become a dash.
  always_comb begin
    o_seg = SEG_DASH;
    if (i_bcd <= BCD_MAX) begin
      case (i_bcd)
        4'd0:    o_seg = 7'b1111110;
        4'd1:    o_seg = 7'b0110000;
        4'd2:    o_seg = 7'b1101101;
        4'd3:    o_seg = 7'b1111001;
        4'd4:    o_seg = 7'b0110011;
        4'd5:    o_seg = 7'b1011011;
        4'd6:    o_seg = 7'b1011111;
        4'd7:    o_seg = 7'b1110000;
        4'd8:    o_seg = 7'b1111111;
        4'd9:    o_seg = 7'b1111011;
        default: o_seg = SEG_DASH;
      endcase
    end
  end

endmodule : BCD_Seven_segment

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a NUM_DIGITS seven-segment display.
// A prescaler divides clk into DIV-cycle digit slots; the first BLANK_CYCLES of
// each slot keep all anodes off so the previous digit's segments never ghost.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses the anode of leading
// zero digits (digit 0 is always shown); slot timing is identical either way.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 1000,
  parameter int BLANK_CYCLES = 16
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    digit_wrap
);

  localparam int PW = $clog2(DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] BLANK_LIM  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_wrap;

  logic [3:0]            w_digits [NUM_DIGITS];
  logic [3:0]            w_digit;
  logic [6:0]            w_seg;
  logic                  w_slot_end;
  logic                  w_in_blank;
  logic                  w_digit_visible;
  logic [NUM_DIGITS-1:0] w_an_onehot;

  // Split the shadow word into per-digit nibbles for the active-digit mux.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digits
      assign w_digits[gi] = r_shadow[4*gi +: 4];
    end
  endgenerate

  assign w_digit     = w_digits[r_idx];
  assign w_slot_end  = (r_presc == PRESC_LAST);
  assign w_in_blank  = (r_presc < BLANK_LIM);
  assign w_an_onehot = AN_ONE << r_idx;

`ifdef LEADING_ZERO_BLANK_EN
  // w_zero_from[k] is set when digit k and every higher digit are zero.
  logic w_zero_from [NUM_DIGITS];

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign w_zero_from[gi] = (w_digits[gi] == 4'd0);
      end else begin : g_mid
        assign w_zero_from[gi] = (w_digits[gi] == 4'd0) && w_zero_from[gi+1];
      end
    end
  endgenerate

  assign w_digit_visible = (r_idx == '0) || !w_zero_from[r_idx];
`else
  assign w_digit_visible = 1'b1;
`endif

  BCD_Seven_segment u_decoder (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

  // Prescaler and digit index; both freeze while the scan is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (en) begin
      if (w_slot_end) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Shadow register; loads are honoured regardless of the scan enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (load) begin
      r_shadow <= bcd_in;
    end
  end

  // Registered outputs derived from the current slot position and shadow digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg  <= SEG_BLANK;
      r_an   <= '0;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_seg  <= w_seg;
      r_an   <= (w_in_blank || !w_digit_visible) ? '0 : w_an_onehot;
      r_wrap <= w_slot_end && (r_idx == IDX_LAST);
    end else begin
      r_seg  <= SEG_BLANK;
      r_an   <= '0;
      r_wrap <= 1'b0;
    end
  end

  assign seg_out    = r_seg;
  assign an_out     = r_an;
  assign digit_wrap = r_wrap;

endmodule : seven_seg_scan_ctrl

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (NUM_DIGITS=4, DIV=8, BLANK_CYCLES=2).
// The reference model tracks only the total number of enabled cycles since reset
// and derives slot, position within slot and wrap from that count arithmetically.
module tb_seven_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int DV = 8;
  localparam int BL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [4*ND-1:0] bcd_in = '0;
  logic [6:0]    seg_out;
  logic [ND-1:0] an_out;
  logic          digit_wrap;

  int compared = 0;
  int mismatched = 0;
  int cycle = 0;

  // Model state: enabled-cycle count since reset and latched BCD word.
  int            m_t = 0;
  logic [4*ND-1:0] m_shadow = '0;
  logic [6:0]    seg_tab [16];

  logic [6:0]    exp_seg;
  logic [ND-1:0] exp_an;
  logic          exp_wrap;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .DIV          (DV),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .bcd_in     (bcd_in),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .digit_wrap (digit_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s cycle %0d: got %h expected %h", tag, cycle, got, want);
    end
  endtask

  // One clock: predict from pre-edge model state and inputs, clock, compare, advance model.
  task automatic tick();
    int p;
    int k;
    int next_t;
    logic [3:0] d;
    logic [4*ND-1:0] next_shadow;
    next_t = m_t;
    next_shadow = m_shadow;
    if (rst) begin
      exp_seg = 7'd0;
      exp_an = '0;
      exp_wrap = 1'b0;
      next_t = 0;
      next_shadow = '0;
    end else begin
      if (en) begin
        p = m_t % DV;
        k = (m_t / DV) % ND;
        d = m_shadow[4*k +: 4];
        exp_seg = seg_tab[d];
        exp_an = (p < BL) ? '0 : ND'(1 << k);
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && (m_shadow >> (4*k)) == 0) exp_an = '0;
`endif
        next_t = m_t + 1;
        exp_wrap = ((next_t % (DV*ND)) == 0);
      end else begin
        exp_seg = 7'd0;
        exp_an = '0;
        exp_wrap = 1'b0;
      end
      if (load) next_shadow = bcd_in;
    end
    @(posedge clk);
    #1;
    cycle++;
    check("seg_out", {1'b0, seg_out}, {1'b0, exp_seg});
    check("an_out", {4'd0, an_out}, {4'd0, exp_an});
    check("digit_wrap", {7'd0, digit_wrap}, {7'd0, exp_wrap});
    m_t = next_t;
    m_shadow = next_shadow;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000;
    seg_tab[2] = 7'b1101101; seg_tab[3] = 7'b1111001;
    seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
    seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000;
    seg_tab[8] = 7'b1111111; seg_tab[9] = 7'b1111011;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0000001;

    // Reset held three cycles, then scan from digit 0 with the blanking window.
    rst = 1'b1; en = 1'b0;
    repeat (3) tick();
    rst = 1'b0; en = 1'b1;
    repeat (3) tick();

    // Load 1234 and scan more than one full frame.
    load = 1'b1; bcd_in = 16'h1234;
    tick();
    load = 1'b0;
    repeat (40) tick();

    // Invalid digit in position 1 shows a dash.
    load = 1'b1; bcd_in = 16'h00A5;
    tick();
    load = 1'b0;
    repeat (32) tick();

    // Disable mid-slot, then resume at the same position.
    repeat (3) tick();
    en = 1'b0;
    repeat (10) tick();
    en = 1'b1;
    repeat (20) tick();

    // Reset pulse in the middle of the digit 2 slot.
    for (int i = 0; i < 64 && !(((m_t / DV) % ND) == 2 && (m_t % DV) == 4); i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (12) tick();

    // Load coincident with a slot change.
    for (int i = 0; i < 16 && (m_t % DV) != DV - 1; i++) tick();
    load = 1'b1; bcd_in = 16'h9876;
    tick();
    load = 1'b0;
    repeat (32) tick();

    // Leading-zero pattern.
    load = 1'b1; bcd_in = 16'h0070;
    tick();
    load = 1'b0;
    repeat (34) tick();

    // Randomized traffic: mostly enabled, occasional loads and rare resets.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 7) == 0);
      bcd_in = 16'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; load = 1'b0; en = 1'b1;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_seven_seg_scan_ctrl
